mem_access_stage: RTL and testbench

//  MEM pipeline stage fed directly by the EX/MEM register. Performs data-memory

---
 rtl/mem_access_stage_if.sv | 28 ++
 rtl/mem_access_stage.sv | 127 ++++++++++++
 tb/tb_mem_access_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// EX/MEM-to-MEM stage bundle: request/branch inputs from the EX/MEM register
// and the stage's load-data, stall and PC-redirect outputs.
interface mem_access_stage_if;
  logic [31:0] ALUResultIn;
  logic [31:0] MemDataIn;
  logic [31:0] ReadData1In;
  logic [31:0] BranchAddResultIn;
  logic [1:0]  BranchIn;
  logic        ZeroIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic [31:0] ReadDataOut;
  logic        MemStall;
  logic        PCSrcOut;
  logic [31:0] BranchTargetOut;

  modport master (
    output ALUResultIn, MemDataIn, ReadData1In, BranchAddResultIn,
    output BranchIn, ZeroIn, MemReadIn, MemWriteIn,
    input  ReadDataOut, MemStall, PCSrcOut, BranchTargetOut
  );

  modport slave (
    input  ALUResultIn, MemDataIn, ReadData1In, BranchAddResultIn,
    input  BranchIn, ZeroIn, MemReadIn, MemWriteIn,
    output ReadDataOut, MemStall, PCSrcOut, BranchTargetOut
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: fixed-latency word-array load/store with pipeline stall,
// plus combinational branch/jr resolution.
module mem_access_stage #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_stage_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                is_store_q, is_store_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [DEPTH];

  logic                req;
  logic [ADDR_W-1:0]   in_idx;
  logic                stall;
  logic                commit;
  logic                commit_en;
  logic [ADDR_W-1:0]   c_idx;
  logic [31:0]         c_data;
  logic                c_store;
  logic                unused_addr_bits;

  assign req              = bus.MemReadIn | bus.MemWriteIn;
  assign in_idx           = bus.ALUResultIn[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.ALUResultIn[31:ADDR_W+2], bus.ALUResultIn[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    stall      = 1'b0;
    commit     = 1'b0;
    c_idx      = idx_q;
    c_data     = wdata_q;
    c_store    = is_store_q;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          idx_d      = in_idx;
          wdata_d    = bus.MemDataIn;
          is_store_d = bus.MemWriteIn;
          cnt_d      = CNT_INIT;
          // Single-cycle latency commits straight from the inputs on the accept edge.
          if (MEM_LATENCY == 1) begin
            commit  = 1'b1;
            c_idx   = in_idx;
            c_data  = bus.MemDataIn;
            c_store = bus.MemWriteIn;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset held across an edge must never let an in-flight access land.
  assign commit_en = commit & rst_n;
  assign rdata_d   = (commit_en && !c_store) ? mem[c_idx] : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit_en && c_store) mem[c_idx] <= c_data;
  end

  assign bus.ReadDataOut = rdata_q;
  assign bus.MemStall    = stall & rst_n;

  always_comb begin
    bus.PCSrcOut        = 1'b0;
    bus.BranchTargetOut = '0;
    if (rst_n) begin
      case (bus.BranchIn)
        2'b01:   bus.PCSrcOut = bus.ZeroIn;
        2'b10:   bus.PCSrcOut = ~bus.ZeroIn;
        2'b11:   bus.PCSrcOut = 1'b1;
        default: bus.PCSrcOut = 1'b0;
      endcase
      bus.BranchTargetOut = (bus.BranchIn == 2'b11) ? bus.ReadData1In : bus.BranchAddResultIn;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a 2-cycle-latency instance and a
// 1-cycle-latency instance checked against a reference word-array model.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_stage_if bus0 ();
  mem_access_stage_if bus1 ();

  mem_access_stage #(.ADDR_W(8), .MEM_LATENCY(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_access_stage #(.ADDR_W(8), .MEM_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [31:0] model   [2][256];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q   [$];

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (!sel) begin
      bus0.MemReadIn = rd; bus0.MemWriteIn = wr; bus0.ALUResultIn = addr; bus0.MemDataIn = data;
    end else begin
      bus1.MemReadIn = rd; bus1.MemWriteIn = wr; bus1.ALUResultIn = addr; bus1.MemDataIn = data;
    end
  endtask

  function automatic logic get_stall(input bit sel);
    return sel ? bus1.MemStall : bus0.MemStall;
  endfunction

  function automatic logic [31:0] get_rdo(input bit sel);
    return sel ? bus1.ReadDataOut : bus0.ReadDataOut;
  endfunction

  // Update the reference model and queue the ReadDataOut expected at DONE.
  task automatic push_expect(input bit sel, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] idx;
    idx = addr[9:2];
    if (wr) model[sel][idx] = data;
    else if (rd) last_rd[sel] = model[sel][idx];
    exp_q.push_back(last_rd[sel]);
  endtask

  task automatic pop_check(input bit sel, input string name);
    logic [31:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, ReadDataOut=%h", name, get_rdo(sel));
    end else begin
      exp = exp_q.pop_front();
      if (get_rdo(sel) !== exp) $display("FAIL %s: ReadDataOut=%h expected %h", name, get_rdo(sel), exp);
      else passed++;
    end
  endtask

  // One complete access with inputs held until the DONE cycle ends.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data, input string name);
    int unsigned n;
    int unsigned lat;
    lat = sel ? 1 : 2;
    @(posedge clk); #1;
    drive(sel, rd, wr, addr, data);
    push_expect(sel, rd, wr, addr, data);
    n = 0;
    @(negedge clk);
    while (get_stall(sel) === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== lat) $display("FAIL %s stall_len: %0d cycles expected %0d", name, n, lat);
    else passed++;
    pop_check(sel, name);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b0, 32'h10, '0);
    bus0.BranchIn = 2'b11; bus0.ReadData1In = 32'h400; bus0.BranchAddResultIn = 32'h123;
    bus0.ZeroIn = 1'b1;
    @(negedge clk);
    total++; if (bus0.MemStall !== 1'b0) $display("FAIL reset_stall: %b expected 0", bus0.MemStall); else passed++;
    total++; if (bus0.PCSrcOut !== 1'b0) $display("FAIL reset_pcsrc: %b expected 0", bus0.PCSrcOut); else passed++;
    total++; if (bus0.BranchTargetOut !== 32'h0) $display("FAIL reset_target: %h expected 0", bus0.BranchTargetOut); else passed++;
    total++; if (bus0.ReadDataOut !== 32'h0) $display("FAIL reset_rdo: %h expected 0", bus0.ReadDataOut); else passed++;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    bus0.BranchIn = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    access(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, "reset_prestore");
    // Store interrupted by reset while BUSY.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    total++; if (bus0.MemStall !== 1'b1) $display("FAIL abort_stall_idle: %b expected 1", bus0.MemStall); else passed++;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    total++; if (bus0.MemStall !== 1'b0) $display("FAIL abort_stall: %b expected 0", bus0.MemStall); else passed++;
    total++; if (bus0.ReadDataOut !== 32'h0) $display("FAIL abort_rdo: %h expected 0", bus0.ReadDataOut); else passed++;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 32'h10, '0, "abort_reload");
  endtask

  task automatic test_latency;
    access(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, "lat2_store");
    access(0, 1'b1, 1'b0, 32'h10, '0, "lat2_load");
  endtask

  task automatic test_wrap;
    access(0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, "wrap_store");
    access(0, 1'b1, 1'b0, 32'h000, '0, "wrap_load0");
    access(0, 1'b1, 1'b0, 32'h003, '0, "wrap_load3");
  endtask

  task automatic test_rw_both;
    access(0, 1'b0, 1'b1, 32'h40, 32'h55, "rw_setup_store");
    access(0, 1'b1, 1'b0, 32'h40, '0, "rw_setup_load");
    access(0, 1'b1, 1'b1, 32'h20, 32'h1, "rw_both");
    access(0, 1'b1, 1'b0, 32'h20, '0, "rw_readback");
  endtask

  task automatic test_branch;
    logic [1:0]  br   [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
    logic        zero [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        epc  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] etgt [6] = '{32'h88, 32'h88, 32'h88, 32'h88, 32'h400, 32'h88};
    bus0.BranchAddResultIn = 32'h88;
    bus0.ReadData1In       = 32'h400;
    for (int i = 0; i < 6; i++) begin
      bus0.BranchIn = br[i];
      bus0.ZeroIn   = zero[i];
      #1;
      total++;
      if (bus0.PCSrcOut !== epc[i]) $display("FAIL branch_pcsrc[%0d]: %b expected %b", i, bus0.PCSrcOut, epc[i]);
      else passed++;
      total++;
      if (bus0.BranchTargetOut !== etgt[i]) $display("FAIL branch_target[%0d]: %h expected %h", i, bus0.BranchTargetOut, etgt[i]);
      else passed++;
    end
    bus0.BranchIn = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic exp_stall [3] = '{1'b1, 1'b0, 1'b1};
    access(1, 1'b0, 1'b1, 32'h8, 32'h77, "b2b_setup");
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h8, '0);
    push_expect(1, 1'b1, 1'b0, 32'h8, '0);
    push_expect(1, 1'b1, 1'b0, 32'h8, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus1.MemStall !== exp_stall[i]) $display("FAIL b2b_stall[%0d]: %b expected %b", i, bus1.MemStall, exp_stall[i]);
      else passed++;
      if (i == 1) pop_check(1, "b2b_first");
    end
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    pop_check(1, "b2b_second");

    // Inputs that change during DONE must not start or alter an access.
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h8, '0);
    push_expect(1, 1'b1, 1'b0, 32'h8, '0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 32'h8, 32'hBAD);
    @(negedge clk);
    total++; if (bus1.MemStall !== 1'b0) $display("FAIL done_ignore_stall: %b expected 0", bus1.MemStall); else passed++;
    pop_check(1, "done_ignore_rdo");
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0);
    access(1, 1'b1, 1'b0, 32'h8, '0, "done_ignore_readback");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[0][i] = 'x;
      model[1][i] = 'x;
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    bus0.BranchIn = 2'b00; bus0.ZeroIn = 1'b0;
    bus0.ReadData1In = '0; bus0.BranchAddResultIn = '0;
    bus1.BranchIn = 2'b00; bus1.ZeroIn = 1'b0;
    bus1.ReadData1In = '0; bus1.BranchAddResultIn = '0;
    test_reset();
    test_latency();
    test_wrap();
    test_rw_both();
    test_branch();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
